ifetch_stage: RTL and testbench

Instruction-fetch stage of the scalar RV32I core. It owns the program counter and drives the instruction memory's byte address. It captures the combinationally returned instruction word into the IF/ID pipeline register and hands it to decode over a valid/ready handshake. It honours branch/jump redirects from execute, stalls on decode back-pressure, and halts on a misaligned redirect target.

---
 rtl/core_pkg.sv | 12 +
 rtl/fetch_pc_gen.sv | 30 +++
 rtl/ifetch_stage.sv | 105 ++++++++++
 tb/tb_ifetch_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the scalar RV32I core: data width, NOP encoding,
// reset vector and the fetch-stage state encoding.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN,
        FETCH_FAULT
    } fetch_state_t;
endpackage

// File: rtl/fetch_pc_gen.sv
// Next-PC selection and misaligned-target detection for the fetch stage.
// Purely combinational; the caller decides whether the results are applied.
module fetch_pc_gen
    import core_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [XLEN-1:0] pc_next,
    output logic            fault_detect,
    output logic            load_ifid
);
    logic misaligned;

    assign misaligned   = |redirect_pc[1:0];
    assign fault_detect = redirect_valid & misaligned;
    // A redirect always wins over a stall, aligned or not.
    assign load_ifid    = ~redirect_valid & ~stall;

    always_comb begin
        if (redirect_valid) begin
            pc_next = redirect_pc;
        end else if (stall) begin
            pc_next = pc;
        end else begin
            pc_next = pc + 32'd4;
        end
    end
endmodule

// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, fills the IF/ID register from a
// combinational instruction memory and hands entries to decode via valid/ready.
module ifetch_stage
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc4,
    output logic        fetch_fault,
    output logic [31:0] fetch_count
);
    fetch_state_t    state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            id_valid_reg, id_valid_next;
    logic [XLEN-1:0] id_pc_reg, id_pc_next;
    logic [XLEN-1:0] id_inst_reg, id_inst_next;
    logic [XLEN-1:0] count_reg, count_next;

    logic            stall;
    logic [XLEN-1:0] gen_pc_next;
    logic            gen_fault;
    logic            gen_load;

    assign stall = id_valid_reg & ~id_ready;

    fetch_pc_gen u_pc_gen (
        .pc             (pc_reg),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .pc_next        (gen_pc_next),
        .fault_detect   (gen_fault),
        .load_ifid      (gen_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FETCH_RUN;
            pc_reg       <= RESET_PC;
            id_valid_reg <= 1'b0;
            id_pc_reg    <= '0;
            id_inst_reg  <= INST_NOP;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            id_valid_reg <= id_valid_next;
            id_pc_reg    <= id_pc_next;
            id_inst_reg  <= id_inst_next;
            count_reg    <= count_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        id_valid_next = id_valid_reg;
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        // Counts the handshake even on the edge where a redirect flushes.
        count_next    = count_reg + {31'd0, id_valid_reg & id_ready};

        case (state_reg)
            FETCH_RUN: begin
                pc_next = gen_pc_next;
                if (redirect_valid) begin
                    id_valid_next = 1'b0;
                    id_pc_next    = '0;
                    id_inst_next  = INST_NOP;
                    if (gen_fault) begin
                        state_next = FETCH_FAULT;
                    end
                end else if (gen_load) begin
                    id_valid_next = 1'b1;
                    id_pc_next    = pc_reg;
                    id_inst_next  = imem_inst;
                end
            end
            FETCH_FAULT: begin
                id_valid_next = 1'b0;
            end
            default: begin
                state_next = FETCH_FAULT;
            end
        endcase
    end

    assign imem_addr   = pc_reg;
    assign id_valid    = id_valid_reg;
    assign id_pc       = id_pc_reg;
    assign id_inst     = id_inst_reg;
    assign id_pc4      = id_pc_reg + 32'd4;
    assign fetch_fault = (state_reg == FETCH_FAULT);
    assign fetch_count = count_reg;
endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: a cycle-level behavioural model checked on
// every falling edge, plus hand-computed literal expectations along the way.
module tb_ifetch_stage;
    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic [31:0] id_pc4;
    logic        fetch_fault;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: what the outputs must be after the most recent edge.
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    bit          m_fault;
    logic [31:0] m_count;

    always #5 clk = ~clk;

    assign imem_inst = imem_addr ^ K;

    ifetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_pc4         (id_pc4),
        .fetch_fault    (fetch_fault),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one edge; the model derives the new state from the rules of the
    // stage using the inputs present before the edge.
    task automatic tick();
        logic [31:0] n_pc, n_id_pc, n_id_inst, n_count;
        bit          n_valid, n_fault;
        n_pc = m_pc; n_valid = m_valid; n_id_pc = m_id_pc;
        n_id_inst = m_id_inst; n_fault = m_fault; n_count = m_count;
        if (rst) begin
            n_pc = 32'd0; n_valid = 0; n_id_pc = 32'd0; n_id_inst = NOP;
            n_fault = 0; n_count = 32'd0;
        end else if (!m_fault) begin
            if (m_valid && id_ready) n_count = m_count + 1;
            if (redirect_valid) begin
                n_pc = redirect_pc;
                n_valid = 0;
                if (redirect_pc % 4 != 0) n_fault = 1;
            end else if (!(m_valid && !id_ready)) begin
                n_valid = 1;
                n_id_pc = m_pc;
                n_id_inst = m_pc ^ K;
                n_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        m_pc = n_pc; m_valid = n_valid; m_id_pc = n_id_pc;
        m_id_inst = n_id_inst; m_fault = n_fault; m_count = n_count;
        chk_en = 1'b1;
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
            chk("fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
            chk("fetch_count", fetch_count, m_count);
            if (m_valid) begin
                chk("id_pc", id_pc, m_id_pc);
                chk("id_inst", id_inst, m_id_inst);
                chk("id_pc4", id_pc4, m_id_pc + 32'd4);
                if (id_ready)
                    $display("xfer pc=%08h inst=%08h count=%0d", id_pc, id_inst, fetch_count);
            end
        end
    end

    initial begin
        m_pc = 32'd0; m_valid = 0; m_id_pc = 32'd0; m_id_inst = NOP;
        m_fault = 0; m_count = 32'd0;

        // Reset and stream
        rst = 1'b1; id_ready = 1'b1;
        tick(); tick();
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, NOP);
        chk("rst_id_pc4", id_pc4, 32'h4);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        rst = 1'b0;
        tick();
        chk("first_valid", {31'd0, id_valid}, 32'd1);
        chk("first_pc", id_pc, 32'h0);
        chk("first_inst", id_inst, 32'hA5A5_0000);
        chk("first_pc4", id_pc4, 32'h4);
        chk("addr4", imem_addr, 32'h4);
        tick();
        chk("addr8", imem_addr, 32'h8);
        tick();
        chk("stream_pc8", id_pc, 32'h8);

        // Stall three cycles with id_pc=8
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_pc", id_pc, 32'h8);
            chk("stall_inst", id_inst, 32'hA5A5_0008);
            chk("stall_addr", imem_addr, 32'hC);
        end
        id_ready = 1'b1;
        tick();
        chk("release_pc", id_pc, 32'hC);
        chk("count3", fetch_count, 32'd3);
        tick();
        chk("pre_redir_pc", id_pc, 32'h10);

        // Redirect
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h40);
        chk("redir_count", fetch_count, 32'd5);
        tick();
        chk("redir_target", id_pc, 32'h40);
        chk("redir_inst", id_inst, 32'hA5A5_0040);

        // Redirect during stall
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
        tick();
        redirect_valid = 1'b0; id_ready = 1'b1;
        chk("stall_redir_valid", {31'd0, id_valid}, 32'd0);
        chk("stall_redir_count", fetch_count, 32'd5);
        tick();
        chk("stall_redir_pc", id_pc, 32'h80);
        chk("stall_redir_count2", fetch_count, 32'd5);

        // Wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("wrap_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", id_pc4, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        tick();
        chk("wrap_next", id_pc, 32'h0);

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h42;
        tick();
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
        chk("mis_addr", imem_addr, 32'h42);
        redirect_pc = 32'h100;
        tick(); tick();
        redirect_valid = 1'b0;
        tick();
        chk("fault_addr", imem_addr, 32'h42);
        chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);

        // Reset out of FAULT, then reset mid-stall
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("unfault_addr", imem_addr, 32'h0);
        chk("unfault_fault", {31'd0, fetch_fault}, 32'd0);
        chk("unfault_count", fetch_count, 32'd0);
        tick(); tick();
        id_ready = 1'b0;
        tick();
        rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        rst = 1'b0; redirect_valid = 1'b0; id_ready = 1'b1;
        chk("rst_stall_addr", imem_addr, 32'h0);
        chk("rst_stall_valid", {31'd0, id_valid}, 32'd0);
        tick(); tick(); tick();
        chk("final_count", fetch_count, 32'd2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
